// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave responder and its synchronizer.
package spi_pkg;

    localparam int SPI_CMD_RD_BIT   = 7;
    localparam int SPI_SYNC_STAGES  = 2;
    localparam int SPI_ADDR_FIELD_W = 7;

    typedef enum logic [1:0] {
        SPI_IDLE = 2'd0,
        SPI_CMD  = 2'd1,
        SPI_DATA = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered rise/fall pulses.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SPI_SYNC_STAGES-1:0] sync_q;
    logic                       prev_q;
    logic                       rise_q;
    logic                       fall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= {SPI_SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SPI_SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SPI_SYNC_STAGES-1];
            rise_q <= sync_q[SPI_SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SPI_SYNC_STAGES-1] & prev_q;
        end
    end

    assign sync_o = sync_q[SPI_SYNC_STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave with a command byte and an 8-bit register file, oversampled in clk.
// Define SPI_SLAVE_AUTOINC_EN to advance the register address after every data byte.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    output logic              miso_oe,
    output logic [7:0]        rx_byte,
    output logic              rx_valid,
    output logic              frame_active,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [7:0]        host_rdata,
    output spi_state_e        dbg_state
);

    logic sclk_hi, sclk_rise, sclk_fall;
    logic ss_hi, ss_rise, ss_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sclk),
        .sync_o (sclk_hi),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // ss resets to the deselected level so frame_active/miso_oe come up low.
    spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (ss),
        .sync_o (ss_hi),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    logic [SPI_SYNC_STAGES-1:0] mosi_sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SPI_SYNC_STAGES-2:0], mosi};
        end
    end

    spi_state_e                  state_q;
    logic [2:0]                  bit_cnt_q;
    logic [7:0]                  shift_in_q;
    logic [7:0]                  shift_out_q;
    logic                        miso_q;
    logic [7:0]                  rx_byte_q;
    logic                        rx_valid_q;
    logic                        is_rd_q;
    logic [SPI_ADDR_FIELD_W-1:0] addr_q;
    logic [1:0]                  warm_q;
    logic                        armed_q;
    logic [7:0]                  host_rdata_q;
    logic [7:0]                  regs_q [DEPTH];

    logic [7:0]                  byte_d;
    logic [SPI_ADDR_FIELD_W-1:0] nxt_addr_d;
    logic [SPI_ADDR_FIELD_W-1:0] load_addr_d;
    logic [7:0]                  load_data_d;

    function automatic logic in_range(input logic [SPI_ADDR_FIELD_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    function automatic logic [7:0] read_reg(input logic [SPI_ADDR_FIELD_W-1:0] a);
        if (in_range(a)) begin
            return regs_q[a[ADDR_W-1:0]];
        end
        return 8'h00;
    endfunction

    function automatic logic [SPI_ADDR_FIELD_W-1:0] next_addr(input logic [SPI_ADDR_FIELD_W-1:0] a);
`ifdef SPI_SLAVE_AUTOINC_EN
        logic [ADDR_W-1:0] wrapped;
        if (!in_range(a)) begin
            return a;
        end
        wrapped = a[ADDR_W-1:0] + 1'b1;
        return SPI_ADDR_FIELD_W'(wrapped);
`else
        return a;
`endif
    endfunction

    always_comb begin
        byte_d      = {shift_in_q[6:0], mosi_sync_q[SPI_SYNC_STAGES-1]};
        nxt_addr_d  = next_addr(addr_q);
        load_addr_d = (state_q == SPI_CMD) ? byte_d[SPI_ADDR_FIELD_W-1:0] : nxt_addr_d;
        load_data_d = read_reg(load_addr_d);
    end

    // A frame may only start after ss has been seen high since reset, so a
    // select held low across reset is not mistaken for a fresh frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SPI_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= 8'h00;
            shift_out_q <= 8'h00;
            miso_q      <= 1'b0;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            is_rd_q     <= 1'b0;
            addr_q      <= '0;
            warm_q      <= 2'b00;
            armed_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            rx_valid_q <= 1'b0;
            warm_q     <= {warm_q[0], 1'b1};
            if (warm_q[1] && ss_hi) begin
                armed_q <= 1'b1;
            end
            if (ss_hi || ss_rise) begin
                state_q     <= SPI_IDLE;
                bit_cnt_q   <= 3'd0;
                shift_in_q  <= 8'h00;
                shift_out_q <= 8'h00;
                miso_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    SPI_IDLE: begin
                        if (ss_fall && armed_q && !sclk_hi) begin
                            state_q <= SPI_CMD;
                        end
                    end
                    SPI_CMD, SPI_DATA: begin
                        if (sclk_rise) begin
                            shift_in_q <= byte_d;
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_byte_q  <= byte_d;
                                rx_valid_q <= 1'b1;
                                if (state_q == SPI_CMD) begin
                                    is_rd_q <= byte_d[SPI_CMD_RD_BIT];
                                    addr_q  <= byte_d[SPI_ADDR_FIELD_W-1:0];
                                    state_q <= SPI_DATA;
                                end else begin
                                    if (!is_rd_q && in_range(addr_q)) begin
                                        regs_q[addr_q[ADDR_W-1:0]] <= byte_d;
                                    end
                                    addr_q <= nxt_addr_d;
                                end
                                if ((state_q == SPI_CMD) ? byte_d[SPI_CMD_RD_BIT] : is_rd_q) begin
                                    shift_out_q <= load_data_d;
                                    miso_q      <= load_data_d[7];
                                end else begin
                                    shift_out_q <= 8'h00;
                                    miso_q      <= 1'b0;
                                end
                            end
                        end else if (sclk_fall && state_q == SPI_DATA && is_rd_q
                                     && bit_cnt_q != 3'd0) begin
                            // The fall right after a load is skipped: bit 7 must
                            // survive until the master's first rise of the byte.
                            shift_out_q <= {shift_out_q[6:0], 1'b0};
                            miso_q      <= shift_out_q[6];
                        end
                    end
                    default: state_q <= SPI_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            host_rdata_q <= 8'h00;
        end else begin
            host_rdata_q <= regs_q[host_addr];
        end
    end

    assign miso         = miso_q;
    assign miso_oe      = ~ss_hi;
    assign frame_active = ~ss_hi;
    assign rx_byte      = rx_byte_q;
    assign rx_valid     = rx_valid_q;
    assign host_rdata   = host_rdata_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a frame table plus burst, abort and reset sequences.
module tb_spi_slave_responder;
    import spi_pkg::*;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       mosi;
    logic       ss;
    logic       miso;
    logic       miso_oe;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_active;
    logic [3:0] host_addr;
    logic [7:0] host_rdata;
    spi_state_e dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int rxv_cnt  = 0;

    spi_slave_responder #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sclk         (sclk),
        .mosi         (mosi),
        .ss           (ss),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .frame_active (frame_active),
        .host_addr    (host_addr),
        .host_rdata   (host_rdata),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rxv_cnt++;
        end
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within 200000 cycles");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       rd;
        logic [7:0] cmd;
        logic [7:0] data;
        logic [3:0] chk_addr;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic ss_low();
        ss = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (HALF) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic host_read(input logic [3:0] a, output logic [7:0] d);
        host_addr = a;
        repeat (2) @(negedge clk);
        d = host_rdata;
    endtask

    initial begin
        logic [7:0] rx0, rx1, rx2, hd;
        int         rxv_before;

        vecs[0] = '{1'b0, 8'h02, 8'h3C, 4'd2,  8'h3C};
        vecs[1] = '{1'b0, 8'h05, 8'hA7, 4'd5,  8'hA7};
        vecs[2] = '{1'b1, 8'h85, 8'h00, 4'd0,  8'hA7};
        vecs[3] = '{1'b1, 8'h82, 8'h5A, 4'd0,  8'h3C};
        vecs[4] = '{1'b0, 8'h20, 8'hFF, 4'd0,  8'h00};
        vecs[5] = '{1'b1, 8'hA0, 8'h00, 4'd0,  8'h00};
        vecs[6] = '{1'b0, 8'h0E, 8'h81, 4'd14, 8'h81};
        vecs[7] = '{1'b1, 8'h8E, 8'h00, 4'd0,  8'h81};
        vecs[8] = '{1'b1, 8'h84, 8'h00, 4'd0,  8'h00};

        rst       = 1'b0;
        sclk      = 1'b0;
        mosi      = 1'b0;
        ss        = 1'b1;
        host_addr = 4'd0;
        repeat (3) @(negedge clk);
        check8("reset_miso", {7'd0, miso}, 8'h00);
        check8("reset_miso_oe", {7'd0, miso_oe}, 8'h00);
        check8("reset_rx_byte", rx_byte, 8'h00);
        check8("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
        check8("reset_frame_active", {7'd0, frame_active}, 8'h00);
        check8("reset_host_rdata", host_rdata, 8'h00);
        check8("reset_state", {6'd0, dbg_state}, {6'd0, SPI_IDLE});
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            rxv_before = rxv_cnt;
            ss_low();
            check8($sformatf("v%0d_frame_active", v), {7'd0, frame_active}, 8'h01);
            spi_bits(vecs[v].cmd, 8, rx0);
            spi_bits(vecs[v].data, 8, rx1);
            ss_high();
            check8($sformatf("v%0d_cmd_miso", v), rx0, 8'h00);
            check8($sformatf("v%0d_rx_valid_count", v), 8'(rxv_cnt - rxv_before), 8'd2);
            check8($sformatf("v%0d_rx_byte", v), rx_byte, vecs[v].data);
            if (vecs[v].rd) begin
                check8($sformatf("v%0d_read_miso", v), rx1, vecs[v].exp);
            end else begin
                check8($sformatf("v%0d_write_miso", v), rx1, 8'h00);
                host_read(vecs[v].chk_addr, hd);
                check8($sformatf("v%0d_host_rdata", v), hd, vecs[v].exp);
            end
        end

        host_read(4'd2, hd);
        check8("oor_reg2_untouched", hd, 8'h3C);

        // Three-byte write burst starting at the top register.
        ss_low();
        spi_bits(8'h0F, 8, rx0);
        spi_bits(8'h11, 8, rx0);
        spi_bits(8'h22, 8, rx0);
        ss_high();
        host_read(4'd15, hd);
`ifdef SPI_SLAVE_AUTOINC_EN
        check8("burst_reg15", hd, 8'h11);
        host_read(4'd0, hd);
        check8("burst_reg0_wrap", hd, 8'h22);
`else
        check8("burst_reg15", hd, 8'h22);
        host_read(4'd0, hd);
        check8("burst_reg0", hd, 8'h00);
`endif

        ss_low();
        spi_bits(8'h8F, 8, rx0);
        spi_bits(8'h00, 8, rx1);
        spi_bits(8'h00, 8, rx2);
        ss_high();
`ifdef SPI_SLAVE_AUTOINC_EN
        check8("burst_rd_b1", rx1, 8'h11);
        check8("burst_rd_b2", rx2, 8'h22);
`else
        check8("burst_rd_b1", rx1, 8'h22);
        check8("burst_rd_b2", rx2, 8'h22);
`endif

        // Abort after five data bits of a write to register 3.
        rxv_before = rxv_cnt;
        ss_low();
        spi_bits(8'h03, 8, rx0);
        spi_bits(8'hEE, 5, rx0);
        ss_high();
        check8("abort_rx_valid_count", 8'(rxv_cnt - rxv_before), 8'd1);
        check8("abort_state", {6'd0, dbg_state}, {6'd0, SPI_IDLE});
        check8("abort_frame_active", {7'd0, frame_active}, 8'h00);
        host_read(4'd3, hd);
        check8("abort_reg3", hd, 8'h00);
        ss_low();
        spi_bits(8'h03, 8, rx0);
        spi_bits(8'h44, 8, rx0);
        ss_high();
        host_read(4'd3, hd);
        check8("after_abort_reg3", hd, 8'h44);

        // Reset asserted in the middle of a command byte, ss held low throughout.
        host_addr = 4'd2;
        ss_low();
        spi_bits(8'h82, 4, rx0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check8("midrst_miso", {7'd0, miso}, 8'h00);
        check8("midrst_miso_oe", {7'd0, miso_oe}, 8'h00);
        check8("midrst_rx_byte", rx_byte, 8'h00);
        check8("midrst_rx_valid", {7'd0, rx_valid}, 8'h00);
        check8("midrst_frame_active", {7'd0, frame_active}, 8'h00);
        check8("midrst_host_rdata", host_rdata, 8'h00);
        check8("midrst_state", {6'd0, dbg_state}, {6'd0, SPI_IDLE});
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rxv_before = rxv_cnt;
        spi_bits(8'h02, 8, rx0);
        spi_bits(8'h55, 8, rx0);
        check8("postrst_no_rx_valid", 8'(rxv_cnt - rxv_before), 8'd0);
        check8("postrst_state", {6'd0, dbg_state}, {6'd0, SPI_IDLE});
        ss_high();
        ss_low();
        spi_bits(8'h07, 8, rx0);
        spi_bits(8'h99, 8, rx0);
        ss_high();
        host_read(4'd7, hd);
        check8("postrst_reg7", hd, 8'h99);
        host_read(4'd2, hd);
        check8("postrst_reg2_cleared", hd, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
